// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// Ports: in_valid/in_ready/op_a/op_b (operand side), out_valid/out_ready/sum/carry_out (result side), busy.
// master = operand source + result consumer, slave = the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: accept at edge T, out_valid high after edge T+WIDTH; issue interval WIDTH+2.
// Backpressure: in_ready only in IDLE; DONE holds sum/carry_out stable until out_ready.
// Ports: clk, rst (async, active-high), bus (serial_adder_if.slave):
//   in_valid/in_ready/op_a/op_b in, out_valid/out_ready/sum/carry_out out, busy = SHIFT or DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_w;
    logic             fa_s;
    logic             fa_c;

    // in_ready is gated by rst so nothing can be accepted while reset is held.
    assign in_ready_w = (state_q == IDLE) && !rst;

    // One-bit full-adder cell fed by the operand LSBs and the carry flop.
    assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_w) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    c_d     = 1'b0;   // no carry may leak from the previous operation
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Sum bits enter at the MSB so the first (LSB) bit ends up at bit 0.
                res_d = {fa_s, res_q[WIDTH-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    sum_d       = res_d;  // includes the bit produced this cycle
                    carry_d     = fa_c;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction-level model: at most one operation in flight; result is a+b
    // to WIDTH+1 bits, valid WIDTH edges after the accept edge.
    logic       pend = 1'b0;
    int         pend_edge = 0;
    logic [W:0] cur = '0;
    logic [W:0] last = '0;
    int         n_results = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_sum", bus.sum, 0);
            chk("rst_carry", bus.carry_out, 0);
            chk("rst_busy", bus.busy, 0);
            pend = 1'b0;
            last = '0;
        end else begin
            chk("mon_in_ready", bus.in_ready, !pend);
            chk("mon_busy", bus.busy, pend);
            chk("mon_out_valid", bus.out_valid, pend && (cyc >= pend_edge + W));
            if (bus.out_valid) begin
                chk("mon_sum", bus.sum, cur[W-1:0]);
                chk("mon_carry", bus.carry_out, cur[W]);
            end else begin
                chk("mon_sum_hold", bus.sum, last[W-1:0]);
                chk("mon_carry_hold", bus.carry_out, last[W]);
            end
            if (bus.in_valid && bus.in_ready) begin
                pend      = 1'b1;
                pend_edge = cyc + 1;
                cur       = {1'b0, bus.op_a} + {1'b0, bus.op_b};
            end else if (bus.out_valid && bus.out_ready) begin
                pend = 1'b0;
                last = cur;
                n_results++;
            end
        end
    end

    int acc_cyc = 0;
    int ov_cyc  = 0;

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) chk("send_timeout", 0, 1);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks literal result, optionally stalls, returns at
    // posedge+1 after the handshake edge.
    task automatic get(input logic [W-1:0] es, input logic ec, input int stall);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) chk("get_timeout", 0, 1);
        ov_cyc = cyc;
        chk("lit_sum", bus.sum, es);
        chk("lit_carry", bus.carry_out, ec);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_sum", bus.sum, es);
                chk("stall_carry", bus.carry_out, ec);
                chk("stall_in_ready", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] pa [16];
    logic [W-1:0] pb [16];

    initial begin
        int sent;
        int start_res;
        int guard;
        logic acc;

        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic add with latency and in_ready return.
        send(8'd100, 8'd55, 1'b0);
        get(8'd155, 1'b0, 0);
        chk("latency", ov_cyc - acc_cyc, W);
        @(negedge clk);
        chk("in_ready_after_hs", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Overflow and full carry ripple.
        send(8'd200, 8'd100, 1'b0);
        get(8'd44, 1'b1, 0);
        send(8'd255, 8'd1, 1'b0);
        get(8'd0, 1'b1, 0);
        send(8'd0, 8'd0, 1'b0);
        get(8'd0, 1'b0, 0);

        // Back-pressure: 5 stalled cycles after out_valid.
        bus.out_ready = 1'b0;
        send(8'd15, 8'd16, 1'b0);
        get(8'd31, 1'b0, 5);

        // Ignore-while-busy: keep presenting 255+255 during the operation.
        send(8'd3, 8'd4, 1'b1);
        bus.op_a = 8'd255;
        bus.op_b = 8'd255;
        @(negedge clk);
        chk("busy_in_ready", bus.in_ready, 0);
        get(8'd7, 1'b0, 0);
        @(negedge clk);
        chk("second_accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        get(8'd254, 1'b1, 0);

        // Reset in the middle of SHIFT.
        send(8'd255, 8'd255, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_carry", bus.carry_out, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(8'd1, 8'd2, 1'b0);
        get(8'd3, 1'b0, 0);

        // Streaming 16 random pairs with random out_ready stalls.
        for (int i = 0; i < 16; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        sent = 0;
        start_res = n_results;
        guard = 0;
        bus.op_a = pa[0];
        bus.op_b = pb[0];
        bus.in_valid = 1'b1;
        while ((n_results - start_res) < 16 && guard < 3000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 16) begin
                    bus.op_a = pa[sent];
                    bus.op_b = pb[sent];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        chk("stream_sent", sent, 16);
        chk("stream_results", n_results - start_res, 16);
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("stream_no_dup", n_results - start_res, 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
